// File: rtl/uart_rx_frame_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and default bit timing.
package uart_rx_frame_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input; resets to 1 so an idle-high
// line does not look like a falling edge when reset is released.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic chain_q [STAGES];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) chain_q[gi] <= 1'b1;
                    else       chain_q[gi] <= d;
                end
            end else begin : g_rest
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) chain_q[gi] <= 1'b1;
                    else       chain_q[gi] <= chain_q[gi-1];
                end
            end
        end
    endgenerate

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// 8N1 LSB-first UART receiver with mid-bit sampling, a one-entry valid/ready holding
// register, and single-cycle framing-error / overrun pulses.
module uart_rx_frame
    import uart_rx_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

    logic rx_s;

    rx_state_e     state_q,     state_d;
    logic [CW-1:0] bit_cnt_q,   bit_cnt_d;
    logic [2:0]    bit_idx_q,   bit_idx_d;
    logic [7:0]    shreg_q,     shreg_d;
    logic [7:0]    data_q,      data_d;
    logic          valid_q,     valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q,   overrun_d;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        // A pop frees the register; a commit below in the same cycle overrides this.
        if (valid_q && ready) valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    bit_cnt_d = '0;
                end
            end
            START: begin
                if (bit_cnt_q == HALF_LAST) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_cnt_q == FULL_LAST) begin
                    bit_cnt_d = '0;
                    shreg_d   = {rx_s, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets a back-to-back start edge be caught.
                if (bit_cnt_q == FULL_LAST) begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                    end else if (!valid_q || ready) begin
                        data_d  = shreg_q;
                        valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
